// File: rtl/fetch_controller.sv
// fetch_controller: sequences instruction fetch between the program counter,
// instruction memory and decode, and arbitrates branch/jump/exception redirects.
//
// Ports:
//   clock, reset            rising-edge clock, asynchronous active-low reset
//   pc_value                current PC word address from program_counter
//   jump_enable, jump_input PC load strobe/value (jump_enable=0 -> PC increments)
//   imem_req                fetch request, address is pc_value
//   imem_ready, imem_data   fetch completion and fetched word
//   instr_valid/word/pc     registered instruction presented to decode
//   instr_accept            decode consumes the presented instruction
//   branch_taken/target     branch redirect
//   jump_req/target         jump / jump-register redirect
//   exception_req           redirect to EXCEPTION_VECTOR
//   redirect_pending        a redirect is latched, waiting for the fetch to complete
module fetch_controller #(
    parameter logic [31:0] RESET_VECTOR     = 32'h00003000,
    parameter logic [31:0] EXCEPTION_VECTOR = 32'h00004180
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:2] pc_value,
    output logic        jump_enable,
    output logic [31:2] jump_input,
    output logic        imem_req,
    input  logic        imem_ready,
    input  logic [31:0] imem_data,
    output logic        instr_valid,
    output logic [31:0] instr_word,
    output logic [31:2] instr_pc,
    input  logic        instr_accept,
    input  logic        branch_taken,
    input  logic [31:2] branch_target,
    input  logic        jump_req,
    input  logic [31:2] jump_target,
    input  logic        exception_req,
    output logic        redirect_pending
);

    localparam int unsigned WORD_W = 32;
    localparam int unsigned PC_W   = 30;

    localparam logic [31:2] RST_TGT = RESET_VECTOR[31:2];
    localparam logic [31:2] EXC_TGT = EXCEPTION_VECTOR[31:2];

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic                instr_valid_nxt;
    logic [WORD_W-1:0]   instr_word_nxt;
    logic [31:2]         instr_pc_nxt;
    logic                pend_nxt;
    logic [31:2]         pend_tgt;
    logic [31:2]         pend_tgt_nxt;

    logic                redir_c;
    logic [31:2]         redir_tgt_c;

    // Redirect arbitration for this cycle: exception > jump > branch
    always_comb begin
        redir_c     = exception_req | jump_req | branch_taken;
        redir_tgt_c = PC_W'(branch_target);
        if (exception_req) begin
            redir_tgt_c = EXC_TGT;
        end else if (jump_req) begin
            redir_tgt_c = PC_W'(jump_target);
        end
    end

    // State register and registered outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state            <= BOOT;
            instr_valid      <= 1'b0;
            instr_word       <= '0;
            instr_pc         <= '0;
            redirect_pending <= 1'b0;
            pend_tgt         <= '0;
        end else begin
            state            <= state_nxt;
            instr_valid      <= instr_valid_nxt;
            instr_word       <= instr_word_nxt;
            instr_pc         <= instr_pc_nxt;
            redirect_pending <= pend_nxt;
            pend_tgt         <= pend_tgt_nxt;
        end
    end

    // Next-state, PC control and fetch handshake
    always_comb begin
        state_nxt       = state;
        instr_valid_nxt = instr_valid;
        instr_word_nxt  = instr_word;
        instr_pc_nxt    = instr_pc;
        pend_nxt        = redirect_pending;
        pend_tgt_nxt    = pend_tgt;
        imem_req        = 1'b0;
        jump_enable     = 1'b1;
        jump_input      = pc_value;

        unique case (state)
            BOOT: begin
                jump_input = RST_TGT;
                state_nxt  = FETCH;
            end

            FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    if (redir_c || redirect_pending) begin
                        // Wrong-path data is dropped; an exception beats a pending redirect
                        if (exception_req) begin
                            jump_input = EXC_TGT;
                        end else if (redirect_pending) begin
                            jump_input = pend_tgt;
                        end else begin
                            jump_input = redir_tgt_c;
                        end
                        pend_nxt = 1'b0;
                    end else begin
                        jump_enable     = 1'b0;
                        instr_valid_nxt = 1'b1;
                        instr_word_nxt  = imem_data;
                        instr_pc_nxt    = pc_value;
                        state_nxt       = HOLD;
                    end
                end else if (redir_c) begin
                    // First redirect wins unless an exception arrives later
                    pend_nxt = 1'b1;
                    if (exception_req || !redirect_pending) begin
                        pend_tgt_nxt = redir_tgt_c;
                    end
                end
            end

            HOLD: begin
                if (redir_c) begin
                    instr_valid_nxt = 1'b0;
                    jump_input      = redir_tgt_c;
                    state_nxt       = FETCH;
                end else if (instr_accept) begin
                    instr_valid_nxt = 1'b0;
                    state_nxt       = FETCH;
                end
            end

            default: begin
                state_nxt = BOOT;
            end
        endcase
    end

endmodule

// File: tb/tb_fetch_controller.sv
// Testbench for fetch_controller: directed test-plan steps followed by a
// randomized phase, checked against a transaction-level model of the fetch
// sequencer together with a model of the program counter it steers.
module tb_fetch_controller;

    localparam logic [31:0] RV = 32'h00003000;
    localparam logic [31:0] EV = 32'h00004180;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:2] pc_value = '0;
    logic        jump_enable;
    logic [31:2] jump_input;
    logic        imem_req;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_data = '0;
    logic        instr_valid;
    logic [31:0] instr_word;
    logic [31:2] instr_pc;
    logic        instr_accept = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:2] branch_target = '0;
    logic        jump_req = 1'b0;
    logic [31:2] jump_target = '0;
    logic        exception_req = 1'b0;
    logic        redirect_pending;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state: mode 0=boot, 1=fetching, 2=instruction held for decode
    int          m_mode = 0;
    bit          m_pend = 1'b0;
    logic [31:2] m_ptgt = '0;
    bit          m_valid = 1'b0;
    logic [31:0] m_word = '0;
    logic [31:2] m_ipc = '0;

    fetch_controller #(
        .RESET_VECTOR    (RV),
        .EXCEPTION_VECTOR(EV)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .pc_value        (pc_value),
        .jump_enable     (jump_enable),
        .jump_input      (jump_input),
        .imem_req        (imem_req),
        .imem_ready      (imem_ready),
        .imem_data       (imem_data),
        .instr_valid     (instr_valid),
        .instr_word      (instr_word),
        .instr_pc        (instr_pc),
        .instr_accept    (instr_accept),
        .branch_taken    (branch_taken),
        .branch_target   (branch_target),
        .jump_req        (jump_req),
        .jump_target     (jump_target),
        .exception_req   (exception_req),
        .redirect_pending(redirect_pending)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit rdy, input logic [31:0] data, input bit acc,
                         input bit br, input logic [31:2] bt,
                         input bit jr, input logic [31:2] jt, input bit exc);
        imem_ready    = rdy;
        imem_data     = data;
        instr_accept  = acc;
        branch_taken  = br;
        branch_target = bt;
        jump_req      = jr;
        jump_target   = jt;
        exception_req = exc;
    endtask

    // One clock: predict the PC and decode-side outcome, check, then advance.
    task automatic cyc();
        logic [31:2] tgt;
        logic [31:2] nxt;
        bit          any;
        bit          adv;
        bit          req;
        any = exception_req | jump_req | branch_taken;
        tgt = exception_req ? EV[31:2] : (jump_req ? jump_target : branch_target);
        adv = 1'b0;
        nxt = pc_value;
        req = (m_mode == 1);
        case (m_mode)
            0: begin
                nxt    = RV[31:2];
                m_mode = 1;
            end
            1: begin
                if (imem_ready) begin
                    if (any || m_pend) begin
                        nxt    = exception_req ? EV[31:2] : (m_pend ? m_ptgt : tgt);
                        m_pend = 1'b0;
                    end else begin
                        adv     = 1'b1;
                        nxt     = pc_value + 30'd1;
                        m_valid = 1'b1;
                        m_word  = imem_data;
                        m_ipc   = pc_value;
                        m_mode  = 2;
                    end
                end else if (any) begin
                    if (exception_req || !m_pend) m_ptgt = tgt;
                    m_pend = 1'b1;
                end
            end
            default: begin
                if (any) begin
                    nxt     = tgt;
                    m_valid = 1'b0;
                    m_mode  = 1;
                end else if (instr_accept) begin
                    m_valid = 1'b0;
                    m_mode  = 1;
                end
            end
        endcase
        #1;
        chk("imem_req", 32'(imem_req), 32'(req));
        chk("jump_enable", 32'(jump_enable), 32'(!adv));
        if (!adv) chk("jump_input", 32'(jump_input), 32'(nxt));
        @(posedge clock);
        #1;
        pc_value = nxt;
        chk("instr_valid", 32'(instr_valid), 32'(m_valid));
        chk("redirect_pending", 32'(redirect_pending), 32'(m_pend));
        if (m_valid) begin
            chk("instr_word", instr_word, m_word);
            chk("instr_pc", 32'(instr_pc), 32'(m_ipc));
        end
    endtask

    task automatic model_reset();
        m_mode  = 0;
        m_pend  = 1'b0;
        m_ptgt  = '0;
        m_valid = 1'b0;
        m_word  = '0;
        m_ipc   = '0;
    endtask

    initial begin
        // Reset values
        #12;
        chk("rst_instr_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr_word", instr_word, 32'd0);
        chk("rst_instr_pc", 32'(instr_pc), 32'd0);
        chk("rst_pending", 32'(redirect_pending), 32'd0);
        chk("rst_imem_req", 32'(imem_req), 32'd0);
        chk("rst_jump_enable", 32'(jump_enable), 32'd1);
        chk("rst_jump_input", 32'(jump_input), 32'h00000C00);
        @(posedge clock);
        #1;
        reset = 1'b1;

        // BOOT cycle, then fetch at 0xC00 with two wait states
        drive(0, '0, 0, 0, '0, 0, '0, 0);
        cyc();
        cyc();
        cyc();
        drive(1, 32'h8C010004, 0, 0, '0, 0, '0, 0);
        cyc();
        chk("tp_word", instr_word, 32'h8C010004);
        chk("tp_pc", 32'(instr_pc), 32'h00000C00);

        // Held until accept; then a branch squashes it
        drive(0, '0, 0, 0, '0, 0, '0, 0);
        cyc();
        cyc();
        drive(0, '0, 0, 1, 30'h00000D00, 0, '0, 0);
        cyc();
        drive(0, '0, 0, 0, '0, 0, '0, 0);
        #1;
        chk("tp_branch_req", 32'(imem_req), 32'd1);
        chk("tp_branch_pc", 32'(jump_input), 32'h00000D00);

        // Pending jump while waiting for memory
        drive(0, '0, 0, 0, '0, 1, 30'h1000F00D, 0);
        cyc();
        drive(0, '0, 0, 0, '0, 0, '0, 0);
        cyc();
        drive(1, 32'hDEADBEEF, 0, 0, '0, 0, '0, 0);
        cyc();
        drive(0, '0, 0, 0, '0, 0, '0, 0);
        #1;
        chk("tp_jump_pc", 32'(jump_input), 32'h1000F00D);

        // Pending jump overwritten by exception; a later branch is ignored
        drive(0, '0, 0, 0, '0, 1, 30'h00000E00, 0);
        cyc();
        drive(0, '0, 0, 0, '0, 0, '0, 1);
        cyc();
        drive(0, '0, 0, 1, 30'h00000123, 0, '0, 0);
        cyc();
        drive(1, 32'h12345678, 0, 0, '0, 0, '0, 0);
        #1;
        chk("tp_exc_load", 32'(jump_input), 32'h00001060);
        cyc();

        // Reach HOLD, then reset between clock edges
        drive(1, 32'hCAFEF00D, 0, 0, '0, 0, '0, 0);
        cyc();
        drive(0, '0, 0, 0, '0, 0, '0, 0);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(instr_valid), 32'd0);
        chk("mid_rst_pending", 32'(redirect_pending), 32'd0);
        chk("mid_rst_jump_enable", 32'(jump_enable), 32'd1);
        chk("mid_rst_jump_input", 32'(jump_input), 32'h00000C00);
        model_reset();
        @(posedge clock);
        #1;
        reset = 1'b1;
        cyc();
        chk("reboot_pc", 32'(pc_value), 32'h00000C00);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            drive(bit'($urandom_range(0, 1)), $urandom, bit'($urandom_range(0, 2) != 0),
                  bit'($urandom_range(0, 9) == 0), 30'($urandom),
                  bit'($urandom_range(0, 9) == 0), 30'($urandom),
                  bit'($urandom_range(0, 14) == 0));
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
